vga_frame_reader: RTL and testbench

- Streams a stored image from the data memory to the VGA colour outputs, driven by the VGA controller's horizontal/vertical counters.
- Generalised successor to the single-mode result viewer:
  - parametrised image size, placement offset and integer pixel replication (SCALE);
  - selectable pixel format;
  - background colour outside the image window;
  - per-frame address restart and a fixed, documented pipeline latency.
- Sits between the VGA sync/counter block and the data memory read port.

---
 rtl/vga_pkg.sv | 19 +
 rtl/pix_decode.sv | 26 ++
 rtl/vga_frame_reader.sv | 153 +++++++++++++++
 tb/tb_vga_frame_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types, widths and the RGB332 expansion helper for the VGA frame reader.
package vga_pkg;

  typedef enum logic [1:0] {
    GRAY8  = 2'd0,
    RGB888 = 2'd1,
    RGB332 = 2'd2
  } pix_fmt_e;

  localparam int unsigned VGA_CNT_W = 10;

  // Widen a 3-3-2 pixel to 8-8-8 by repeating each field's MSBs into the low bits.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            {4{d[1:0]}}};
  endfunction

endpackage

// File: rtl/pix_decode.sv
// Combinational pixel-format decode from a memory word to {R,G,B}.
module pix_decode
  import vga_pkg::*;
#(
  parameter int unsigned MODE   = 0,
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  output logic [23:0]       rgb_c
);

  // Bits above the pixel field are ignored for every format.
  logic unused_data;
  assign unused_data = ^data;

  // Select the decode for the configured pixel format.
  always_comb begin
    rgb_c = {3{data[7:0]}};
    if (MODE == 32'(RGB888)) begin
      rgb_c = data[23:0];
    end else if (MODE == 32'(RGB332)) begin
      rgb_c = expand_rgb332(data[7:0]);
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Streams a stored image to the VGA colour outputs from the raster counters,
// with placement offset, integer replication and a fixed 2-clock latency.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned H_OFF    = 0,
  parameter int unsigned V_OFF    = 0,
  parameter int unsigned SCALE    = 1,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MODE     = 0,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VGA_CNT_W-1:0] H_Count_Value,
  input  logic [VGA_CNT_W-1:0] V_Count_Value,
  input  logic                 en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [7:0]           R,
  output logic [7:0]           G,
  output logic [7:0]           B,
  output logic                 pix_active,
  output logic                 frame_start
);

  localparam int unsigned WIN_W = IMG_W * SCALE;
  localparam int unsigned WIN_H = IMG_H * SCALE;
  localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned COL_W = $clog2(IMG_W + 1);

  logic [32:0]       h_rel, v_rel;
  logic              win, h_last, restart, first_pix;
  logic [SUB_W-1:0]  x_sub, y_sub, x_eff, y_eff, x_nxt, y_nxt;
  logic [COL_W-1:0]  col, col_eff, col_nxt;
  logic [ADDR_W-1:0] row_base, row_eff, row_nxt, addr_nxt;
  logic              win_d1, win_d2, fs_d1, fs_d2;
  logic              stalled;
  logic [DATA_W-1:0] rdata_hold, dec_data;
  logic [23:0]       rgb_c;

  // Window test on offset-relative counters; the sign bit catches counts before the offset.
  assign h_rel     = 33'(H_Count_Value) - 33'(H_OFF);
  assign v_rel     = 33'(V_Count_Value) - 33'(V_OFF);
  assign win       = !h_rel[32] && (h_rel[31:0] < WIN_W) &&
                     !v_rel[32] && (v_rel[31:0] < WIN_H);
  assign h_last    = win && (h_rel[31:0] == WIN_W - 1);
  assign first_pix = win && (h_rel[31:0] == '0) && (v_rel[31:0] == '0);
  assign restart   = (H_Count_Value == '0) && (V_Count_Value == '0);

  // Incremental address walk; a frame restart zeroes the counters before this cycle's step.
  always_comb begin
    x_eff    = restart ? '0 : x_sub;
    y_eff    = restart ? '0 : y_sub;
    col_eff  = restart ? '0 : col;
    row_eff  = restart ? '0 : row_base;
    x_nxt    = x_eff;
    y_nxt    = y_eff;
    col_nxt  = col_eff;
    row_nxt  = row_eff;
    addr_nxt = mem_addr;
    if (win) begin
      addr_nxt = row_eff + ADDR_W'(col_eff);
      if (h_last) begin
        x_nxt   = '0;
        col_nxt = '0;
        if (y_eff == SUB_W'(SCALE - 1)) begin
          y_nxt   = '0;
          row_nxt = row_eff + ADDR_W'(IMG_W);
        end else begin
          y_nxt = y_eff + SUB_W'(1);
        end
      end else if (x_eff == SUB_W'(SCALE - 1)) begin
        x_nxt   = '0;
        col_nxt = col_eff + COL_W'(1);
      end else begin
        x_nxt = x_eff + SUB_W'(1);
      end
    end
  end

  // Address counters, read address and the two window/frame-start delay stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sub    <= '0;
      y_sub    <= '0;
      col      <= '0;
      row_base <= '0;
      mem_addr <= '0;
      win_d1   <= 1'b0;
      win_d2   <= 1'b0;
      fs_d1    <= 1'b0;
      fs_d2    <= 1'b0;
    end else if (en) begin
      x_sub    <= x_nxt;
      y_sub    <= y_nxt;
      col      <= col_nxt;
      row_base <= row_nxt;
      mem_addr <= addr_nxt;
      win_d1   <= win;
      win_d2   <= win_d1;
      fs_d1    <= first_pix;
      fs_d2    <= fs_d1;
    end
  end

  // The memory keeps reading while frozen, so keep the word that belongs to the frozen stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalled    <= 1'b0;
      rdata_hold <= '0;
    end else if (!en) begin
      stalled <= 1'b1;
      if (!stalled) begin
        rdata_hold <= mem_rdata;
      end
    end else begin
      stalled <= 1'b0;
    end
  end

  assign dec_data = stalled ? rdata_hold : mem_rdata;

  pix_decode #(
    .MODE   (MODE),
    .DATA_W (DATA_W)
  ) u_pix_decode (
    .data  (dec_data),
    .rgb_c (rgb_c)
  );

  // Output register: image colour inside the delayed window, background elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {R, G, B}   <= BG_COLOR;
      pix_active  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      if (win_d2) begin
        {R, G, B}  <= rgb_c;
        pix_active <= 1'b1;
      end else begin
        {R, G, B}  <= BG_COLOR;
        pix_active <= 1'b0;
      end
      frame_start <= fs_d2;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: four configurations driven by one small raster,
// checked every cycle against a division-based image model plus literal anchors.
module tb_vga_frame_reader;

  localparam int NI    = 4;
  localparam int H_TOT = 12;
  localparam int V_TOT = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic [9:0] h     = 10'd11;
  logic [9:0] v     = 10'd9;

  logic [18:0] maddr [NI];
  logic [31:0] rdata [NI];
  logic [7:0]  r [NI];
  logic [7:0]  g [NI];
  logic [7:0]  b [NI];
  logic        pa [NI];
  logic        fs [NI];

  // Per-instance configuration, mirrored from the instance parameters below.
  int          iw    [NI] = '{4, 4, 3, 2};
  int          ih    [NI] = '{2, 2, 2, 2};
  int          isc   [NI] = '{1, 2, 1, 4};
  int          iho   [NI] = '{0, 0, 2, 1};
  int          ivo   [NI] = '{0, 0, 1, 0};
  int          imode [NI] = '{0, 0, 2, 1};
  logic [23:0] ibg   [NI] = '{24'h204060, 24'h000000, 24'h0A0B0C, 24'h112233};

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  vga_frame_reader #(.IMG_W(4), .IMG_H(2), .H_OFF(0), .V_OFF(0), .SCALE(1), .ADDR_W(19),
                     .DATA_W(32), .MODE(0), .BG_COLOR(24'h204060)) u0 (
    .clk(clk), .rst_n(rst_n), .H_Count_Value(h), .V_Count_Value(v), .en(en),
    .mem_addr(maddr[0]), .mem_rdata(rdata[0]), .R(r[0]), .G(g[0]), .B(b[0]),
    .pix_active(pa[0]), .frame_start(fs[0]));

  vga_frame_reader #(.IMG_W(4), .IMG_H(2), .H_OFF(0), .V_OFF(0), .SCALE(2), .ADDR_W(19),
                     .DATA_W(32), .MODE(0), .BG_COLOR(24'h000000)) u1 (
    .clk(clk), .rst_n(rst_n), .H_Count_Value(h), .V_Count_Value(v), .en(en),
    .mem_addr(maddr[1]), .mem_rdata(rdata[1]), .R(r[1]), .G(g[1]), .B(b[1]),
    .pix_active(pa[1]), .frame_start(fs[1]));

  vga_frame_reader #(.IMG_W(3), .IMG_H(2), .H_OFF(2), .V_OFF(1), .SCALE(1), .ADDR_W(19),
                     .DATA_W(32), .MODE(2), .BG_COLOR(24'h0A0B0C)) u2 (
    .clk(clk), .rst_n(rst_n), .H_Count_Value(h), .V_Count_Value(v), .en(en),
    .mem_addr(maddr[2]), .mem_rdata(rdata[2]), .R(r[2]), .G(g[2]), .B(b[2]),
    .pix_active(pa[2]), .frame_start(fs[2]));

  vga_frame_reader #(.IMG_W(2), .IMG_H(2), .H_OFF(1), .V_OFF(0), .SCALE(4), .ADDR_W(19),
                     .DATA_W(32), .MODE(1), .BG_COLOR(24'h112233)) u3 (
    .clk(clk), .rst_n(rst_n), .H_Count_Value(h), .V_Count_Value(v), .en(en),
    .mem_addr(maddr[3]), .mem_rdata(rdata[3]), .R(r[3]), .G(g[3]), .B(b[3]),
    .pix_active(pa[3]), .frame_start(fs[3]));

  // Image contents per instance; upper bits carry junk the decoder must ignore.
  function automatic logic [31:0] mem_word(input int i, input logic [18:0] a);
    case (i)
      2:       return {24'hDEAD5A, 8'(a * 19'h35 + 19'hAB)};
      3:       return {8'hEE, 24'(24'h123456 + 24'(a) * 24'h010101)};
      default: return 32'(a);
    endcase
  endfunction

  // Synchronous memory: data one clock after the address.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) rdata[i] <= mem_word(i, maddr[i]);
  end

  function automatic bit in_win(input int i, input int hh, input int vv);
    return (hh >= iho[i]) && (hh < iho[i] + iw[i] * isc[i]) &&
           (vv >= ivo[i]) && (vv < ivo[i] + ih[i] * isc[i]);
  endfunction

  // Stored pixel shown at a screen position: divide out the replication.
  function automatic int pix_addr(input int i, input int hh, input int vv);
    return ((vv - ivo[i]) / isc[i]) * iw[i] + (hh - iho[i]) / isc[i];
  endfunction

  function automatic logic [23:0] decode(input int i, input logic [31:0] d);
    int r3, g3, b2;
    r3 = int'(d[7:5]);
    g3 = int'(d[4:2]);
    b2 = int'(d[1:0]);
    case (imode[i])
      1:       return d[23:0];
      2:       return {8'(r3 * 36 + r3 / 2), 8'(g3 * 36 + g3 / 2), 8'(b2 * 85)};
      default: return {d[7:0], d[7:0], d[7:0]};
    endcase
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  // Model state: expected outputs and the last two enabled raster samples.
  logic [18:0] e_addr [NI];
  logic [23:0] e_rgb  [NI];
  bit          e_pa   [NI];
  bit          e_fs   [NI];
  int          p1h, p1v, p2h, p2v;
  bit          p1ok, p2ok;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      e_addr[i] = '0;
      e_rgb[i]  = ibg[i];
      e_pa[i]   = 1'b0;
      e_fs[i]   = 1'b0;
    end
    p1ok = 1'b0;
    p2ok = 1'b0;
  endtask

  // Every cycle: advance the model on enabled edges, then compare all outputs.
  initial begin : chk_proc
    forever begin
      @(posedge clk);
      if (rst_n && en) begin
        for (int i = 0; i < NI; i++) begin
          if (p2ok && in_win(i, p2h, p2v)) begin
            e_rgb[i] = decode(i, mem_word(i, 19'(pix_addr(i, p2h, p2v))));
            e_pa[i]  = 1'b1;
            e_fs[i]  = (p2h == iho[i]) && (p2v == ivo[i]);
          end else begin
            e_rgb[i] = ibg[i];
            e_pa[i]  = 1'b0;
            e_fs[i]  = 1'b0;
          end
          if (in_win(i, int'(h), int'(v))) e_addr[i] = 19'(pix_addr(i, int'(h), int'(v)));
        end
        p2h = p1h; p2v = p1v; p2ok = p1ok;
        p1h = int'(h); p1v = int'(v); p1ok = 1'b1;
      end
      #1;
      if (chk_on && rst_n) begin
        for (int i = 0; i < NI; i++) begin
          check("mem_addr", i, 32'(maddr[i]), 32'(e_addr[i]));
          check("rgb", i, {8'h00, r[i], g[i], b[i]}, {8'h00, e_rgb[i]});
          check("pix_active", i, 32'(pa[i]), 32'(e_pa[i]));
          check("frame_start", i, 32'(fs[i]), 32'(e_fs[i]));
        end
      end
    end
  end

  // Hand-computed anchors, checked after the tick that samples (hh,vv) in frame 1.
  // kind: 0 mem_addr, 1 {R,G,B}, 2 pix_active, 3 frame_start
  typedef struct packed {
    logic [1:0]  inst;
    logic [9:0]  hh;
    logic [9:0]  vv;
    logic [1:0]  kind;
    logic [23:0] val;
  } lit_t;

  lit_t lits [15] = '{
    '{2'd0, 10'd3, 10'd1, 2'd0, 24'd7},
    '{2'd0, 10'd2, 10'd1, 2'd0, 24'd6},
    '{2'd0, 10'd3, 10'd1, 2'd1, 24'h050505},
    '{2'd0, 10'd5, 10'd0, 2'd1, 24'h030303},
    '{2'd0, 10'd6, 10'd0, 2'd1, 24'h204060},
    '{2'd0, 10'd6, 10'd0, 2'd2, 24'd0},
    '{2'd1, 10'd3, 10'd0, 2'd0, 24'd1},
    '{2'd1, 10'd2, 10'd1, 2'd0, 24'd1},
    '{2'd1, 10'd1, 10'd2, 2'd0, 24'd4},
    '{2'd1, 10'd7, 10'd3, 2'd0, 24'd7},
    '{2'd1, 10'd5, 10'd1, 2'd1, 24'h010101},
    '{2'd2, 10'd4, 10'd1, 2'd1, 24'hB649FF},
    '{2'd3, 10'd3, 10'd0, 2'd1, 24'h123456},
    '{2'd3, 10'd3, 10'd0, 2'd3, 24'd1},
    '{2'd0, 10'd2, 10'd0, 2'd3, 24'd1}
  };

  task automatic check_lit(input int k);
    int          i;
    logic [23:0] act;
    i = int'(lits[k].inst);
    case (lits[k].kind)
      2'd0:    act = 24'(maddr[i]);
      2'd1:    act = {r[i], g[i], b[i]};
      2'd2:    act = 24'(pa[i]);
      default: act = 24'(fs[i]);
    endcase
    check($sformatf("anchor%0d", k), i, 32'(act), 32'(lits[k].val));
  endtask

  task automatic tick(input int hh, input int vv);
    @(negedge clk);
    en = 1'b1;
    h  = 10'(hh);
    v  = 10'(vv);
    @(posedge clk);
    #2;
  endtask

  task automatic stall_tick();
    @(negedge clk);
    en = 1'b0;
    h  = 10'($urandom_range(0, 1023));
    v  = 10'($urandom_range(0, 1023));
    @(posedge clk);
    #2;
  endtask

  int fs_cnt [NI];

  task automatic run_frame(input int fr);
    for (int vv = 0; vv < V_TOT; vv++) begin
      for (int hh = 0; hh < H_TOT; hh++) begin
        if (fr == 2 && vv == 1 && hh == 3) begin
          repeat (3) stall_tick();
        end
        tick(hh, vv);
        if (fr == 1) begin
          for (int k = 0; k < 15; k++)
            if (int'(lits[k].hh) == hh && int'(lits[k].vv) == vv) check_lit(k);
        end
        if (fr == 2) begin
          for (int i = 0; i < NI; i++) fs_cnt[i] += int'(fs[i]);
          if (hh == 0 && vv == 0) begin
            check("restart_addr", 0, 32'(maddr[0]), 32'd0);
            check("restart_addr", 1, 32'(maddr[1]), 32'd0);
          end
        end
        if (fr == 3 && vv == 1 && hh == 5) return;
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    for (int i = 0; i < NI; i++) begin
      check({name, "_addr"}, i, 32'(maddr[i]), 32'd0);
      check({name, "_rgb"}, i, {8'h00, r[i], g[i], b[i]}, {8'h00, ibg[i]});
      check({name, "_pa"}, i, 32'(pa[i]), 32'd0);
      check({name, "_fs"}, i, 32'(fs[i]), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("reset");

    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    run_frame(1);

    for (int i = 0; i < NI; i++) fs_cnt[i] = 0;
    run_frame(2);
    for (int i = 0; i < NI; i++) check("fs_per_frame", i, 32'(fs_cnt[i]), 32'd1);

    // Asynchronous reset mid-line, observed before any further clock edge.
    run_frame(3);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    h = 10'd11;
    v = 10'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(4);
    repeat (3) tick(H_TOT - 1, V_TOT - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
